sync_fifo_param: RTL and testbench
==================================

Name: sync_fifo_param

Overview:
Parametrised single-clock FIFO. Next generation of the team's synchronous FIFO.
- Adds a non-power-of-two depth, a selectable first-word-fall-through (FWFT) read mode, runtime-programmable almost-full/almost-empty thresholds, an occupancy output, a read-valid strobe, and sticky error flags with a clear.
- Sits between producer/consumer stages inside one clock domain; drop-in buffer for the UVM-verified datapath.

Parameters:
WIDTH, 16, data word width in bits (>=1)
DEPTH, 8, number of entries (>=2, need not be a power of two)
FWFT, 0, 0 = standard read (data one cycle after rd_en); 1 = head word visible on data_out whenever not empty
CNT_W, $clog2(DEPTH+1), occupancy width (derived, not overridden)

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous reset, active-high
wr_en  in  1  write request
data_in  in  WIDTH  write data
rd_en  in  1  read/pop request
data_out  out  WIDTH  read data
rd_valid  out  1  data_out holds a newly read word (standard) / head word valid (FWFT)
wr_ack  out  1  previous-cycle write accepted
overflow  out  1  previous-cycle write rejected
underflow  out  1  previous-cycle read rejected
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= af_thresh
almost_empty  out  1  count <= ae_thresh
af_thresh  in  CNT_W  almost-full threshold
ae_thresh  in  CNT_W  almost-empty threshold
level  out  CNT_W  current occupancy
err_sticky  out  2  {overflow seen, underflow seen}; held until clr_err
clr_err  in  1  clears err_sticky

Behaviour:
- Reset (rst=1 at a clock edge): wr_ptr, rd_ptr and count are 0. data_out, rd_valid, wr_ack, overflow, underflow and err_sticky are 0. Memory contents are not cleared. A reset mid-operation discards all contents on that edge, and requests in the same cycle are ignored.
- wr_accept = wr_en && (!full || rd_accept). Writing while full is accepted only with a simultaneous accepted read (pass-through slot).
- rd_accept = rd_en && !empty. Reading while empty is always rejected, even with a simultaneous write.
- Pointer wrap: a pointer at DEPTH-1 advances to 0. No modulo-2^n wrap.
- count: +1 on write-only accept, -1 on read-only accept, unchanged on both or neither. count never exceeds DEPTH and never goes below 0.
- full, empty, almost_full, almost_empty and level are combinational from registered count.
- Threshold edge cases: af_thresh=0 makes almost_full always 1. ae_thresh>=DEPTH makes almost_empty always 1.
- wr_ack, overflow and underflow are registered one-cycle pulses for the request of the prior cycle.
  - wr_ack = wr_accept.
  - overflow = wr_en && !wr_accept.
  - underflow = rd_en && !rd_accept.
- err_sticky bits set on the same edge as their pulse. clr_err clears them, but a same-cycle new error wins (set has priority over clear).
- FWFT=0:
  - On rd_accept, data_out <= mem[rd_ptr] and rd_valid <= 1 (latency 1). Otherwise rd_valid <= 0.
  - data_out holds its last value.
- FWFT=1:
  - data_out = mem[rd_ptr] combinationally; rd_valid = !empty.
  - rd_en pops the head. A word written into an empty FIFO is visible the cycle after the write edge.
- Simultaneous read and write on the same entry is impossible: when empty the read is rejected, and when full the write targets the slot being freed, with the read capturing old data first.

Decomposition:
- Package fifo_pkg: fifo_mode_e {STD, FWFT}; function clog2-based CNT_W helper; err bit index constants ERR_OVF=1, ERR_UDF=0.
- Sub-module fifo_mem: a WIDTH×DEPTH register array with 1 write port and 1 asynchronous read port. The top level holds pointers, count, flags and the read register.

Test Plan:
- Reset, then write 0x0001..0x0008 (DEPTH=8): wr_ack pulses 8×; full=1, level=8 after the 8th write; a 9th write gives overflow=1, err_sticky=2'b10, level stays 8.
- FWFT=0: drain 8 reads → data_out 0x0001..0x0008, each one cycle after rd_en with rd_valid=1; a 9th read gives underflow=1, err_sticky[0]=1, empty=1.
- Full with wr_en=rd_en=1 and data_in=0xAAAA: read returns the oldest word, the write is accepted, level stays 8, no overflow. Empty with both asserted: the write is accepted, underflow=1, level becomes 1.
- Wrap at DEPTH=6: 20 interleaved write/read pairs of an incrementing pattern → data returns in order, pointers wrap 5→0, level never exceeds 6.
- af_thresh=6, ae_thresh=1: fill to 5 → almost_full=0; at 6 → 1. Drain to 1 → almost_empty=1. With clr_err=1 and no new error, err_sticky → 0.
- FWFT=1: write 0x1234 into an empty FIFO → next cycle data_out=0x1234 and rd_valid=1 with no rd_en. Assert rst mid-fill at level=4 → next cycle level=0, empty=1, rd_valid=0, data_out=0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the parametrised synchronous FIFO.
package fifo_pkg;

  typedef enum logic {STD = 1'b0, FWFT = 1'b1} fifo_mode_e;

  localparam int ERR_OVF = 1;
  localparam int ERR_UDF = 0;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// WIDTH x DEPTH register array: one synchronous write port, one asynchronous read port.
module fifo_mem #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with arbitrary depth, optional first-word-fall-through,
// programmable almost-full/almost-empty thresholds and sticky error flags.
module sync_fifo_param #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int FWFT  = 0,
  parameter int CNT_W = fifo_pkg::cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] data_in,
  input  logic             rd_en,
  output logic [WIDTH-1:0] data_out,
  output logic             rd_valid,
  output logic             wr_ack,
  output logic             overflow,
  output logic             underflow,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  input  logic [CNT_W-1:0] af_thresh,
  input  logic [CNT_W-1:0] ae_thresh,
  output logic [CNT_W-1:0] level,
  output logic [1:0]       err_sticky,
  input  logic             clr_err
);
  import fifo_pkg::*;

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam fifo_mode_e MODE = (FWFT != 0) ? fifo_pkg::FWFT : fifo_pkg::STD;

  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             wr_accept, rd_accept;
  logic             ovf_now, udf_now;
  logic [WIDTH-1:0] mem_rdata;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full         = (count == CNT_W'(DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (count >= af_thresh);
  assign almost_empty = (count <= ae_thresh);
  assign level        = count;

  assign rd_accept = rd_en && !empty;
  // When full, a write can only land in the slot being vacated by a read.
  assign wr_accept = wr_en && (!full || rd_accept);
  assign ovf_now   = wr_en && !wr_accept;
  assign udf_now   = rd_en && !rd_accept;

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (wr_accept && !rst),
    .waddr (wr_ptr),
    .wdata (data_in),
    .raddr (rd_ptr),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      wr_ack     <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
      err_sticky <= 2'b00;
    end else begin
      if (wr_accept) wr_ptr <= next_ptr(wr_ptr);
      if (rd_accept) rd_ptr <= next_ptr(rd_ptr);
      case ({wr_accept, rd_accept})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      wr_ack    <= wr_accept;
      overflow  <= ovf_now;
      underflow <= udf_now;
      // A new error in the same cycle beats a clear.
      err_sticky[ERR_OVF] <= ovf_now || (err_sticky[ERR_OVF] && !clr_err);
      err_sticky[ERR_UDF] <= udf_now || (err_sticky[ERR_UDF] && !clr_err);
    end
  end

  generate
    if (MODE == fifo_pkg::FWFT) begin : g_fwft
      assign data_out = empty ? '0 : mem_rdata;
      assign rd_valid = !empty;
    end else begin : g_std
      logic [WIDTH-1:0] data_q;
      logic             valid_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          data_q  <= '0;
          valid_q <= 1'b0;
        end else begin
          valid_q <= rd_accept;
          if (rd_accept) data_q <= mem_rdata;
        end
      end

      assign data_out = data_q;
      assign rd_valid = valid_q;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: standard mode DEPTH=8, wrap at DEPTH=6, FWFT DEPTH=8.
module tb_sync_fifo_param;

  logic        clk = 1'b0;
  logic        rst, wr_en, rd_en, clr_err;
  logic [15:0] data_in;
  logic [3:0]  af_thresh, ae_thresh;

  always #5 clk = ~clk;

  // DUT a: DEPTH=8, standard read
  logic [15:0] a_dout;
  logic        a_valid, a_ack, a_ovf, a_udf, a_full, a_empty, a_af, a_ae;
  logic [3:0]  a_level;
  logic [1:0]  a_err;

  sync_fifo_param #(.WIDTH(16), .DEPTH(8), .FWFT(0)) dut_a (
    .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .data_out(a_dout), .rd_valid(a_valid), .wr_ack(a_ack), .overflow(a_ovf),
    .underflow(a_udf), .full(a_full), .empty(a_empty), .almost_full(a_af),
    .almost_empty(a_ae), .af_thresh(af_thresh), .ae_thresh(ae_thresh),
    .level(a_level), .err_sticky(a_err), .clr_err(clr_err)
  );

  // DUT b: DEPTH=6, standard read
  logic [15:0] b_dout;
  logic        b_valid, b_ack, b_ovf, b_udf, b_full, b_empty, b_af, b_ae;
  logic [2:0]  b_level;
  logic [1:0]  b_err;
  logic [2:0]  b_af_thresh, b_ae_thresh;
  assign b_af_thresh = af_thresh[2:0];
  assign b_ae_thresh = ae_thresh[2:0];

  sync_fifo_param #(.WIDTH(16), .DEPTH(6), .FWFT(0)) dut_b (
    .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .data_out(b_dout), .rd_valid(b_valid), .wr_ack(b_ack), .overflow(b_ovf),
    .underflow(b_udf), .full(b_full), .empty(b_empty), .almost_full(b_af),
    .almost_empty(b_ae), .af_thresh(b_af_thresh), .ae_thresh(b_ae_thresh),
    .level(b_level), .err_sticky(b_err), .clr_err(clr_err)
  );

  // DUT c: DEPTH=8, first-word-fall-through
  logic [15:0] c_dout;
  logic        c_valid, c_ack, c_ovf, c_udf, c_full, c_empty, c_af, c_ae;
  logic [3:0]  c_level;
  logic [1:0]  c_err;

  sync_fifo_param #(.WIDTH(16), .DEPTH(8), .FWFT(1)) dut_c (
    .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .data_out(c_dout), .rd_valid(c_valid), .wr_ack(c_ack), .overflow(c_ovf),
    .underflow(c_udf), .full(c_full), .empty(c_empty), .almost_full(c_af),
    .almost_empty(c_ae), .af_thresh(af_thresh), .ae_thresh(ae_thresh),
    .level(c_level), .err_sticky(c_err), .clr_err(clr_err)
  );

  logic unused_outs;
  assign unused_outs = ^{b_ack, b_ovf, b_udf, b_full, b_af, b_ae, b_err,
                         c_ack, c_ovf, c_udf, c_full, c_af, c_ae, c_err};

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s [%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // flags order: {rd_valid, wr_ack, overflow, underflow, full, empty, almost_full, almost_empty}
  typedef struct {
    logic        wr, rd, clr;
    logic [15:0] din;
    logic [3:0]  af, ae;
    logic [15:0] exp_dout;
    logic [7:0]  exp_flags;
    logic [3:0]  exp_level;
    logic [1:0]  exp_err;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic wr, input logic rd, input logic clr,
                              input logic [15:0] din, input logic [3:0] af, input logic [3:0] ae,
                              input logic [15:0] dout, input logic [7:0] flags,
                              input logic [3:0] lvl, input logic [1:0] err);
    vec_t v;
    v.wr = wr; v.rd = rd; v.clr = clr; v.din = din; v.af = af; v.ae = ae;
    v.exp_dout = dout; v.exp_flags = flags; v.exp_level = lvl; v.exp_err = err;
    return v;
  endfunction

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
    data_in = '0; af_thresh = 4'd6; ae_thresh = 4'd1;

    // fill, overflow, pass-through when full, drain, underflow, both-on-empty, error clear
    vq.push_back(mk(1,0,0,16'h0001,4'd6,4'd1, 16'h0000,8'b01000001,4'd1,2'b00));
    vq.push_back(mk(1,0,0,16'h0002,4'd6,4'd1, 16'h0000,8'b01000000,4'd2,2'b00));
    vq.push_back(mk(1,0,0,16'h0003,4'd6,4'd1, 16'h0000,8'b01000000,4'd3,2'b00));
    vq.push_back(mk(1,0,0,16'h0004,4'd6,4'd1, 16'h0000,8'b01000000,4'd4,2'b00));
    vq.push_back(mk(1,0,0,16'h0005,4'd6,4'd1, 16'h0000,8'b01000000,4'd5,2'b00));
    vq.push_back(mk(1,0,0,16'h0006,4'd6,4'd1, 16'h0000,8'b01000010,4'd6,2'b00));
    vq.push_back(mk(1,0,0,16'h0007,4'd6,4'd1, 16'h0000,8'b01000010,4'd7,2'b00));
    vq.push_back(mk(1,0,0,16'h0008,4'd6,4'd1, 16'h0000,8'b01001010,4'd8,2'b00));
    vq.push_back(mk(1,0,0,16'h0009,4'd6,4'd1, 16'h0000,8'b00101010,4'd8,2'b10));
    vq.push_back(mk(1,1,0,16'hAAAA,4'd6,4'd1, 16'h0001,8'b11001010,4'd8,2'b10));
    vq.push_back(mk(0,1,0,16'h0000,4'd6,4'd1, 16'h0002,8'b10000010,4'd7,2'b10));
    vq.push_back(mk(0,1,0,16'h0000,4'd6,4'd1, 16'h0003,8'b10000010,4'd6,2'b10));
    vq.push_back(mk(0,1,0,16'h0000,4'd6,4'd1, 16'h0004,8'b10000000,4'd5,2'b10));
    vq.push_back(mk(0,1,0,16'h0000,4'd6,4'd1, 16'h0005,8'b10000000,4'd4,2'b10));
    vq.push_back(mk(0,1,0,16'h0000,4'd6,4'd1, 16'h0006,8'b10000000,4'd3,2'b10));
    vq.push_back(mk(0,1,0,16'h0000,4'd6,4'd1, 16'h0007,8'b10000000,4'd2,2'b10));
    vq.push_back(mk(0,1,0,16'h0000,4'd6,4'd1, 16'h0008,8'b10000001,4'd1,2'b10));
    vq.push_back(mk(0,1,0,16'h0000,4'd6,4'd1, 16'hAAAA,8'b10000101,4'd0,2'b10));
    vq.push_back(mk(0,1,0,16'h0000,4'd6,4'd1, 16'hAAAA,8'b00010101,4'd0,2'b11));
    vq.push_back(mk(1,1,0,16'h5555,4'd6,4'd1, 16'hAAAA,8'b01010001,4'd1,2'b11));
    vq.push_back(mk(0,0,1,16'h0000,4'd6,4'd1, 16'hAAAA,8'b00000001,4'd1,2'b00));
    vq.push_back(mk(0,1,0,16'h0000,4'd6,4'd1, 16'h5555,8'b10000101,4'd0,2'b00));
    vq.push_back(mk(0,1,1,16'h0000,4'd6,4'd1, 16'h5555,8'b00010101,4'd0,2'b01));
    vq.push_back(mk(0,0,0,16'h0000,4'd0,4'd8, 16'h5555,8'b00000111,4'd0,2'b01));

    // reset state
    step();
    chk("rst_dout",  0, 32'(a_dout), 32'h0);
    chk("rst_flags", 0, 32'({a_valid,a_ack,a_ovf,a_udf,a_full,a_empty,a_af,a_ae}), 32'b00000101);
    chk("rst_level", 0, 32'(a_level), 32'd0);
    chk("rst_err",   0, 32'(a_err), 32'd0);
    rst = 1'b0;

    foreach (vq[i]) begin
      wr_en = vq[i].wr; rd_en = vq[i].rd; clr_err = vq[i].clr; data_in = vq[i].din;
      af_thresh = vq[i].af; ae_thresh = vq[i].ae;
      step();
      chk("vec_dout",  i, 32'(a_dout), 32'(vq[i].exp_dout));
      chk("vec_flags", i, 32'({a_valid,a_ack,a_ovf,a_udf,a_full,a_empty,a_af,a_ae}), 32'(vq[i].exp_flags));
      chk("vec_level", i, 32'(a_level), 32'(vq[i].exp_level));
      chk("vec_err",   i, 32'(a_err), 32'(vq[i].exp_err));
    end
    wr_en = 0; rd_en = 0; clr_err = 0; af_thresh = 4'd6; ae_thresh = 4'd1;

    // wrap at DEPTH=6: prefill 3 then 20 simultaneous write/read cycles, then drain
    rst = 1'b1; step(); rst = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      wr_en = 1; data_in = 16'(k); step();
    end
    chk("wrap_prefill_level", 0, 32'(b_level), 32'd3);
    for (int k = 0; k < 20; k++) begin
      wr_en = 1; rd_en = 1; data_in = 16'(k + 4); step();
      chk("wrap_dout",  k, 32'(b_dout), 32'(k + 1));
      chk("wrap_valid", k, 32'(b_valid), 32'd1);
      chk("wrap_level", k, 32'(b_level), 32'd3);
    end
    wr_en = 0;
    for (int k = 0; k < 3; k++) begin
      rd_en = 1; step();
      chk("wrap_drain", k, 32'(b_dout), 32'(k + 21));
    end
    rd_en = 0;
    chk("wrap_empty", 0, 32'(b_empty), 32'd1);
    // exactly-full at DEPTH=6, then one more write overflows
    for (int k = 0; k < 6; k++) begin
      wr_en = 1; data_in = 16'(k); step();
    end
    chk("d6_full",  0, 32'({b_full, b_level}), 32'({1'b1, 3'd6}));
    step();
    chk("d6_ovf",   0, 32'({b_ovf, b_level}), 32'({1'b1, 3'd6}));
    wr_en = 0;

    // FWFT: head visible without rd_en, mid-fill reset, pop
    rst = 1'b1; step(); rst = 1'b0;
    chk("fwft_rst_valid", 0, 32'(c_valid), 32'd0);
    wr_en = 1; data_in = 16'h1234; step();
    wr_en = 0;
    chk("fwft_head",  0, 32'(c_dout), 32'h1234);
    chk("fwft_valid", 0, 32'(c_valid), 32'd1);
    for (int k = 2; k <= 4; k++) begin
      wr_en = 1; data_in = 16'(k); step();
    end
    wr_en = 0;
    chk("fwft_lvl4", 0, 32'({c_level, c_dout}), 32'({4'd4, 16'h1234}));
    rd_en = 1; step(); rd_en = 0;
    chk("fwft_pop", 0, 32'({c_level, c_dout}), 32'({4'd3, 16'h0002}));
    wr_en = 1; data_in = 16'h0005; step();
    chk("fwft_refill", 0, 32'(c_level), 32'd4);
    rst = 1'b1; data_in = 16'h0006; step();
    rst = 1'b0; wr_en = 0;
    chk("fwft_mid_rst", 0, 32'({c_level, c_empty, c_valid, c_dout}), 32'({4'd0, 1'b1, 1'b0, 16'h0000}));
    wr_en = 1; data_in = 16'h00BB; step();
    data_in = 16'h00CC; step();
    wr_en = 0;
    chk("fwft_head2", 0, 32'(c_dout), 32'h00BB);
    rd_en = 1; step();
    chk("fwft_pop2", 0, 32'(c_dout), 32'h00CC);
    step(); rd_en = 0;
    chk("fwft_drained", 0, 32'({c_empty, c_valid}), 32'({1'b1, 1'b0}));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
